// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: latches rising-edge interrupts, masks them and hands the lowest-index winner to the interrupt-control block.
// Define INT_SYNC_EN to pass irq through a 2-flop synchronizer before edge detection.
module interrupt_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] irq,
    input  logic        glob_en,
    input  logic        mask_we,
    input  logic [15:0] mask_wdata,
    input  logic        int_ack,
    output logic        int_en,
    output logic [3:0]  int_val,
    output logic [15:0] pending,
    output logic [15:0] mask
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t state, state_next;
    logic hold_cnt, hold_next;
    logic [1:0] arm;
    logic [3:0] val_next, winner;
    logic [15:0] sample, prev, edges, eligible, clr;
`ifdef INT_SYNC_EN
    localparam logic [1:0] ARM_DONE = 2'd3;
    logic [15:0] sync1, sync2;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end
    assign sample = sync2;
`else
    localparam logic [1:0] ARM_DONE = 2'd1;
    assign sample = irq;
`endif
    // Edges are suppressed until the delayed copy holds real post-reset data, so a line held high through release is not seen as an edge.
    assign edges = (arm == ARM_DONE) ? (sample & ~prev) : '0;
    assign eligible = pending & mask;
    assign int_en = (state == REQ);
    always_comb begin
        winner = '0;
        for (int i = 15; i >= 0; i--)
            if (eligible[i]) winner = 4'(i);
    end
    always_comb begin
        state_next = state;
        hold_next = 1'b0;
        val_next = int_val;
        clr = '0;
        case (state)
            IDLE: if (glob_en && |eligible) begin
                state_next = REQ;
                val_next = winner;
            end
            REQ: if (int_ack) begin
                state_next = HOLD;
                clr = 16'(1) << int_val;
            end else if (!glob_en) state_next = IDLE;
            HOLD: begin
                hold_next = 1'b1;
                if (hold_cnt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            hold_cnt <= 1'b0;
            int_val <= '0;
            pending <= '0;
            mask <= '0;
            prev <= '0;
            arm <= '0;
        end else begin
            state <= state_next;
            hold_cnt <= hold_next;
            int_val <= val_next;
            // A fresh edge wins over the acknowledge clear of the same line.
            pending <= (pending & ~clr) | edges;
            if (mask_we) mask <= mask_wdata;
            prev <= sample;
            if (arm != ARM_DONE) arm <= arm + 2'd1;
        end
    end
endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have port: irq  input  16  external interrupt lines, rising-edge sensitive, line n = vector n.
REQ-004 SHALL have port: glob_en  input  1  processor interrupt-enable flag (E bit).
REQ-005 SHALL have port: mask_we  input  1  write strobe for mask register.
REQ-006 SHALL have port: mask_wdata  input  16  new mask value; bit n = 1 enables line n.
REQ-007 SHALL have port: int_ack  input  1  one-cycle pulse from the interrupt-control block when it has taken the request.
REQ-008 SHALL have port: int_en  output  1  interrupt request to the interrupt-control block.
REQ-009 SHALL have port: int_val  output  4  vector number of the requested interrupt.
REQ-010 SHALL have port: pending  output  16  latched pending flags, readable.
REQ-011 SHALL have port: mask  output  16  current mask register.

Function
REQ-012 SHALL set pending[n] on each detected rising edge of irq[n], independent of mask and glob_en.
REQ-013 SHALL update mask on every clock edge where mask_we = 1; mask takes effect for arbitration the following cycle.
REQ-014 SHALL treat line n as eligible when pending[n] & mask[n]; lowest index has highest priority.
REQ-015 SHALL implement FSM states IDLE, REQ, HOLD.
REQ-016 IDLE: when glob_en = 1 and any line is eligible, SHALL latch winning index into int_val and go to REQ; int_en = 1 from the next cycle.
REQ-017 REQ: int_en = 1, int_val SHALL stay stable; a higher-priority line becoming eligible SHALL NOT change int_val.
REQ-018 REQ: on int_ack = 1, SHALL clear pending[int_val], deassert int_en next cycle, and go to HOLD.
REQ-019 REQ: if glob_en = 0 and int_ack = 0, SHALL return to IDLE, int_en = 0 next cycle, pending retained; int_ack and glob_en = 0 in the same cycle counts as ack.
REQ-020 HOLD: SHALL stay exactly 2 cycles with int_en = 0 (lets the injected INT instruction clear E), then go to IDLE.
REQ-021 SHALL ignore int_ack outside REQ.
REQ-022 If a new edge on line n coincides with the ack-clear of pending[n], pending[n] SHALL remain 1 (set wins).
REQ-023 A mask bit cleared while its line is in REQ SHALL NOT withdraw the request.
REQ-024 Minimum request-to-request spacing SHALL be 4 cycles (REQ ack, 2 HOLD, IDLE decision).

Reset
REQ-025 On reset SHALL force: state IDLE, int_en = 0, int_val = 0, pending = 0x0000, mask = 0x0000, edge/sync registers = 0.
REQ-026 Reset mid-request SHALL drop int_en immediately (asynchronously); pending events are lost.
REQ-027 A line held high through reset release SHALL NOT produce an edge; a new 0->1 transition is required.

Configuration
REQ-028 Macro INT_SYNC_EN defined: each irq line SHALL pass through a 2-flop synchronizer before edge detection; edge-to-pending latency = 3 clock edges.
REQ-029 Macro INT_SYNC_EN undefined: irq SHALL be edge-detected directly against a 1-flop delayed copy; edge-to-pending latency = 1 clock edge.
REQ-030 All other behaviour SHALL be identical in both builds.

Verification (build without INT_SYNC_EN unless noted)
REQ-031 mask = 0xFFFF, glob_en = 1, pulse irq[5] -> pending = 0x0020 after 1 edge, int_en = 1 with int_val = 5; int_ack -> pending = 0x0000, int_en low for at least 3 cycles.
REQ-032 mask = 0xFFFF, irq[9] and irq[2] rise together -> int_val = 2 first; after ack and HOLD, int_val = 9.
REQ-033 mask = 0x0000, pulse irq[3] -> pending = 0x0008, int_en stays 0; write mask = 0x0008 -> int_en = 1, int_val = 3.
REQ-034 In REQ with int_val = 4, drop glob_en without ack -> int_en = 0 next cycle, pending[4] stays 1; restore glob_en -> request reissued with int_val = 4.
REQ-035 Assert reset while int_en = 1 -> int_en, int_val, pending, mask all 0 immediately; irq held high across release gives no request.
REQ-036 INT_SYNC_EN build: rising edge of irq[0] -> pending[0] set on the third clock edge, not earlier.
